nibble_assembler: RTL and testbench
===================================

# nibble_assembler

Receive-side counterpart of the nibble swapper. It accepts a 4-bit nibble stream over a valid/ready handshake and pairs nibbles into bytes. The per-byte `swap_en` flag selects nibble order, so swapped bytes return to their natural `{hi,lo}` order. Completed bytes are buffered in a small FIFO and offered downstream over a second valid/ready handshake.

## Interface
- `DEPTH`, default 4: output FIFO depth in bytes. Must be a power of two and at least 2.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high. Clears the FSM, the FIFO and `err_swap`.
- `nib_in` in 4: input nibble.
- `nib_valid` in 1: `nib_in` is valid.
- `nib_ready` out 1: block can accept a nibble. A nibble transfers when `nib_valid && nib_ready`.
- `swap_en` in 1: nibble-order flag, latched with the first nibble of each byte.
  - 1: first nibble is the low nibble.
  - 0: first nibble is the high nibble.
- `sync` in 1: resynchronise; discards any partial byte.
- `byte_out` out 8: FIFO head byte.
- `byte_valid` out 1: FIFO not empty.
- `byte_ready` in 1: downstream accepts. A byte transfers when `byte_valid && byte_ready`.
- `count` out clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `err_swap` out 1: sticky flag for a `swap_en` mismatch within a byte.

## Operation
- FSM states:
  - `IDLE`: no nibble held.
  - `HALF`: first nibble held in `first_nib`, with its order flag held in `swap_q`.
- `IDLE` → `HALF` on a nibble transfer. `first_nib <= nib_in`, `swap_q <= swap_en`.
- `HALF` → `IDLE` on a nibble transfer. The assembled byte is pushed into the FIFO:
  - `swap_q`=0: byte = `{first_nib, nib_in}`.
  - `swap_q`=1: byte = `{nib_in, first_nib}`.
- `nib_ready = !sync && (state==IDLE || count<DEPTH)`.
  - A first nibble is always accepted.
  - A completing nibble waits for FIFO space.
  - There is no combinational path from `byte_ready` to `nib_ready`.
- `sync`=1 for one cycle:
  - State goes to `IDLE`, and any held nibble is dropped.
  - No nibble is accepted that cycle.
  - FIFO contents and the downstream side are unaffected.
- `err_swap`:
  - Set when, in `HALF`, a nibble transfers with `swap_en != swap_q`. The byte is still assembled using `swap_q`.
  - Cleared only by `reset`.
- FIFO behaviour:
  - Circular buffer with wrap-around read and write pointers of clog2(DEPTH) bits.
  - Push and pop in the same cycle leave `count` unchanged. This is legal at any occupancy, including empty→push (the byte appears next cycle) and full→pop.
  - Push while full cannot occur, because `nib_ready` gates it.
- `byte_out` is undefined while `byte_valid`=0. The bench must not check it then.
- Reset values:
  - State `IDLE`, `count`=0, `byte_valid`=0, `byte_out`=8'h00, `err_swap`=0.
  - `nib_ready`=1, since it is derived from state and count.
- Reset mid-byte or with a non-empty FIFO discards everything. The first nibble after reset release is treated as a first nibble.
- If `reset` and `sync` are asserted together, `reset` wins.

## Timing
- Latency: a completing nibble transferred at edge N raises `byte_valid` with that byte on `byte_out` after edge N, i.e. in cycle N+1, when the FIFO was empty.
- Throughput: one byte every two cycles with continuous `nib_valid` and `byte_ready`=1.
- `byte_out`, `byte_valid`, `count` and `err_swap` are registered.
- `nib_ready` is combinational from registered state, registered `count` and `sync`.
- Outputs hold stable while `byte_valid && !byte_ready`.

## Test plan
- Natural order: `swap_en`=0, nibbles 0xA then 0x5, `byte_ready`=1 → `byte_out`=8'hA5 with `byte_valid`=1 for exactly one cycle, one cycle after the second nibble.
- Swapped order: `swap_en`=1, nibbles 0xA then 0x5 → 8'h5A. Then stream a swapped stream of 0x12,0x34 (nibbles 2,1,4,3 with `swap_en`=1) → 8'h12, 8'h34 in order.
- Backpressure:
  - Hold `byte_ready`=0 and stream 2·DEPTH+1 nibbles (0x0..0x8) with `swap_en`=0 → `count` reaches 4 (with DEPTH=4) and `nib_ready` drops in `HALF`.
  - Then release `byte_ready` → bytes 8'h01, 8'h23, 8'h45, 8'h67 emerge, followed by 8'h89 once its nibble is accepted.
  - Also check a simultaneous push/pop keeps `count` constant.
- Resync: nibble 0xF, then `sync`=1 for one cycle, then nibbles 0x3, 0xC (`swap_en`=0) → only 8'h3C is output; 0xF is discarded.
- Swap mismatch: first nibble 0x1 with `swap_en`=1, second nibble 0x2 with `swap_en`=0 → byte 8'h21 and `err_swap`=1. `err_swap` stays 1 until `reset`.
- Reset mid-operation: with 2 bytes buffered and state `HALF`, pulse `reset` → next cycle `count`=0, `byte_valid`=0, `byte_out`=8'h00, `err_swap`=0, `nib_ready`=1. Then nibbles 0x7, 0x7 → 8'h77.

Source files
------------

// File: rtl/nibble_assembler.sv
// rtl/nibble_assembler.sv - pairs a valid/ready nibble stream into bytes and buffers them in a FIFO
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   nib_in/nib_valid    input nibble stream; nib_ready accepts it
//   swap_en             nibble order of the byte, latched with its first nibble
//   sync                drops any half-assembled byte; blocks input that cycle
//   byte_out/byte_valid FIFO head; byte_ready pops it
//   count               FIFO occupancy 0..DEPTH
//   err_swap            sticky: swap_en changed between the two nibbles of a byte
module nibble_assembler #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               nib_in,
  input  logic                     nib_valid,
  output logic                     nib_ready,
  input  logic                     swap_en,
  input  logic                     sync,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_swap
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HALF = 1'b1;

  logic [0:0]    state;
  logic [3:0]    first_nib;
  logic          swap_q;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] count_next;
  logic [7:0]    push_data;
  logic [7:0]    head_next;
  logic          nib_fire;
  logic          push;
  logic          pop;

  // Only a completing nibble needs FIFO space; a first nibble is just held.
  assign nib_ready = !sync && (state == ST_IDLE || count < DEPTH_C);
  assign nib_fire  = nib_valid && nib_ready;
  assign push      = nib_fire && (state == ST_HALF);
  assign pop       = byte_valid && byte_ready;

  // The byte is always assembled with the order latched on its first nibble.
  assign push_data = swap_q ? {nib_in, first_nib} : {first_nib, nib_in};

  assign rd_next    = rd_ptr + AW'(pop);
  assign count_next = count + CW'(push) - CW'(pop);

  // byte_out is a register, so compute what the head will be after this edge.
  // If the slot being written is the next head (FIFO empty, or one entry
  // being popped), bypass the write data since mem is not updated yet.
  assign head_next = (push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      first_nib  <= 4'h0;
      swap_q     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      byte_valid <= 1'b0;
      byte_out   <= 8'h00;
      err_swap   <= 1'b0;
    end else begin
      if (sync) begin
        state <= ST_IDLE;
      end else if (nib_fire) begin
        if (state == ST_IDLE) begin
          state     <= ST_HALF;
          first_nib <= nib_in;
          swap_q    <= swap_en;
        end else begin
          state <= ST_IDLE;
          if (swap_en != swap_q) begin
            err_swap <= 1'b1;
          end
        end
      end

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr     <= rd_next;
      count      <= count_next;
      byte_valid <= (count_next != '0);
      if (count_next != '0) begin
        byte_out <= head_next;
      end
    end
  end

endmodule

// File: tb/tb_nibble_assembler.sv
// tb/tb_nibble_assembler.sv - scoreboard bench for nibble_assembler
module tb_nibble_assembler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] nib_in;
  logic       nib_valid;
  logic       nib_ready;
  logic       swap_en;
  logic       sync;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic [2:0] count;
  logic       err_swap;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  nibble_assembler #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .nib_in     (nib_in),
    .nib_valid  (nib_valid),
    .nib_ready  (nib_ready),
    .swap_en    (swap_en),
    .sync       (sync),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .count      (count),
    .err_swap   (err_swap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every byte handshake is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && byte_valid && byte_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %02h expected none", byte_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (byte_out !== e) begin
          errors++;
          $display("FAIL byte_out: got %02h expected %02h", byte_out, e);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send_nib(input logic [3:0] n, input logic sw);
    int t;
    nib_in    = n;
    swap_en   = sw;
    nib_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!nib_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!nib_ready) begin
      checks++;
      errors++;
      $display("FAIL nib_timeout: got nib_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    nib_valid = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1; nib_in = 4'h0; nib_valid = 1'b0; swap_en = 1'b0;
    sync = 1'b0; byte_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_valid", byte_valid, 0);
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_err", err_swap, 0);
    check("rst_nib_ready", nib_ready, 1);
    tick();

    // Natural order, one-cycle valid pulse
    exp_q.push_back(8'hA5);
    send_nib(4'hA, 1'b0);
    send_nib(4'h5, 1'b0);
    @(negedge clk);
    check("nat_valid", byte_valid, 1);
    check("nat_byte", byte_out, 8'hA5);
    @(negedge clk);
    check("nat_valid_pulse", byte_valid, 0);
    tick();

    // Swapped order and swapped stream
    exp_q.push_back(8'h5A);
    send_nib(4'hA, 1'b1);
    send_nib(4'h5, 1'b1);
    exp_q.push_back(8'h12);
    send_nib(4'h2, 1'b1);
    send_nib(4'h1, 1'b1);
    exp_q.push_back(8'h34);
    send_nib(4'h4, 1'b1);
    send_nib(4'h3, 1'b1);
    repeat (3) tick();

    // Backpressure: fill FIFO, hold a half byte
    byte_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 1) exp_q.push_back({4'(i - 1), 4'(i)});
      send_nib(4'(i), 1'b0);
    end
    @(negedge clk);
    check("bp_count_full", count, 4);
    check("bp_nib_ready_low", nib_ready, 0);
    check("bp_head_stable", byte_out, 8'h01);
    tick();
    exp_q.push_back(8'h89);
    fork
      send_nib(4'h9, 1'b0);
      begin
        repeat (3) tick();
        byte_ready = 1'b1;
      end
    join
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      t++;
      tick();
    end
    check("bp_drained", exp_q.size(), 0);
    tick();

    // Simultaneous push and pop at count 1
    byte_ready = 1'b0;
    exp_q.push_back(8'hBC);
    send_nib(4'hB, 1'b0);
    send_nib(4'hC, 1'b0);
    exp_q.push_back(8'hDE);
    send_nib(4'hD, 1'b0);
    @(negedge clk);
    check("pp_count_before", count, 1);
    tick();
    byte_ready = 1'b1;
    send_nib(4'hE, 1'b0);
    @(negedge clk);
    check("pp_count_same", count, 1);
    check("pp_head_next", byte_out, 8'hDE);
    repeat (3) tick();

    // Resync discards held nibble
    send_nib(4'hF, 1'b0);
    sync = 1'b1;
    @(negedge clk);
    check("sync_nib_ready", nib_ready, 0);
    tick();
    sync = 1'b0;
    exp_q.push_back(8'h3C);
    send_nib(4'h3, 1'b0);
    send_nib(4'hC, 1'b0);
    repeat (3) tick();

    // Swap mismatch
    check("err_before", err_swap, 0);
    exp_q.push_back(8'h21);
    send_nib(4'h1, 1'b1);
    send_nib(4'h2, 1'b0);
    @(negedge clk);
    check("err_set", err_swap, 1);
    tick();
    exp_q.push_back(8'h66);
    send_nib(4'h6, 1'b0);
    send_nib(4'h6, 1'b0);
    repeat (3) tick();
    check("err_sticky", err_swap, 1);

    // Reset with two bytes buffered and a half byte held
    byte_ready = 1'b0;
    send_nib(4'h1, 1'b0);
    send_nib(4'h2, 1'b0);
    send_nib(4'h3, 1'b0);
    send_nib(4'h4, 1'b0);
    send_nib(4'h5, 1'b0);
    @(negedge clk);
    check("mid_count", count, 2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", byte_valid, 0);
    check("mid_rst_byte_out", byte_out, 8'h00);
    check("mid_rst_err", err_swap, 0);
    check("mid_rst_nib_ready", nib_ready, 1);
    tick();
    byte_ready = 1'b1;
    exp_q.push_back(8'h77);
    send_nib(4'h7, 1'b0);
    send_nib(4'h7, 1'b0);
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      t++;
      tick();
    end
    repeat (3) tick();
    check("final_drained", exp_q.size(), 0);
    check("final_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
